// File: rtl/parallel_match_aligner.sv
// parallel_match_aligner: locks onto the detector's first match offset and emits stream words re-aligned to bit 0.
// Define PMA_RECHECK_EN to recheck the sync bit once per frame and drop lock after NUM_Miss consecutive misses.
module parallel_match_aligner #(
  parameter int WID_Bitstream = 8,
  parameter int LAT_Position = 2,
  parameter int NUM_Frame = 16,
  parameter int NUM_Miss = 3,
  localparam int OW = $clog2(WID_Bitstream)
) (
  input  logic                     local_PMA_clk,
  input  logic                     local_PMA_reset,
  input  logic                     local_PMA_newstream,
  input  logic [WID_Bitstream-1:0] local_PMA_bitstream,
  input  logic [WID_Bitstream-1:0] local_PMA_position,
  output logic                     PMA_local_busy,
  output logic                     PMA_local_locked,
  output logic [OW-1:0]            PMA_local_offset,
  output logic [WID_Bitstream-1:0] PMA_local_data,
  output logic                     PMA_local_valid,
  input  logic                     local_PMA_ready,
  output logic                     PMA_local_overflow
);
  if (NUM_Frame < 2 || NUM_Miss < 1 || LAT_Position < 1) begin : g_bad_cfg
    $error("parallel_match_aligner: invalid parameters");
  end
  typedef enum logic [1:0] {IDLE, SEARCH, LOCKED} state_t;
  state_t state, state_nx;
  logic [WID_Bitstream-1:0] dl [LAT_Position+1];
  logic [WID_Bitstream-1:0] aligned;
  logic [OW-1:0] low;
  logic lose;
  // dl[LAT_Position-1] is d[n], the word the current mask describes; dl[LAT_Position] is d[n-1]
  always_ff @(posedge local_PMA_clk or posedge local_PMA_reset) begin
    if (local_PMA_reset) begin
      for (int k = 0; k <= LAT_Position; k++) dl[k] <= '0;
    end else begin
      dl[0] <= local_PMA_bitstream;
      for (int k = 1; k <= LAT_Position; k++) dl[k] <= dl[k-1];
    end
  end
  assign aligned = WID_Bitstream'({dl[LAT_Position-1], dl[LAT_Position]} >> PMA_local_offset);
  always_comb begin
    low = '0;
    for (int i = WID_Bitstream-1; i >= 0; i--) if (local_PMA_position[i]) low = OW'(i);
  end
`ifdef PMA_RECHECK_EN
  localparam int FW = $clog2(NUM_Frame);
  localparam int MW = $clog2(NUM_Miss+1);
  logic [FW-1:0] frame;
  logic [MW-1:0] miss;
  logic boundary, hit;
  assign boundary = state == LOCKED && frame == FW'(NUM_Frame-1);
  assign hit = local_PMA_position[PMA_local_offset];
  assign lose = boundary && !hit && miss == MW'(NUM_Miss-1);
  always_ff @(posedge local_PMA_clk or posedge local_PMA_reset) begin
    if (local_PMA_reset) begin
      frame <= '0;
      miss <= '0;
    end else if (local_PMA_newstream || state != LOCKED) begin
      frame <= '0;
      miss <= '0;
    end else begin
      frame <= boundary ? '0 : frame + 1'b1;
      if (boundary) miss <= hit ? '0 : miss + 1'b1;
    end
  end
`else
  assign lose = 1'b0;
`endif
  always_comb begin
    state_nx = IDLE;
    if (local_PMA_newstream) state_nx = SEARCH;
    else
      case (state)
        IDLE:    state_nx = IDLE;
        SEARCH:  state_nx = |local_PMA_position ? LOCKED : SEARCH;
        LOCKED:  state_nx = lose ? SEARCH : LOCKED;
        default: state_nx = IDLE;
      endcase
  end
  always_ff @(posedge local_PMA_clk or posedge local_PMA_reset) begin
    if (local_PMA_reset) state <= IDLE;
    else state <= state_nx;
  end
  assign PMA_local_busy = state != IDLE;
  assign PMA_local_locked = state == LOCKED;
  // an unaccepted word is overwritten rather than stalling the stream
  always_ff @(posedge local_PMA_clk or posedge local_PMA_reset) begin
    if (local_PMA_reset) begin
      PMA_local_offset <= '0;
      PMA_local_data <= '0;
      PMA_local_valid <= 1'b0;
      PMA_local_overflow <= 1'b0;
    end else if (local_PMA_newstream) begin
      PMA_local_offset <= '0;
      PMA_local_valid <= 1'b0;
      PMA_local_overflow <= 1'b0;
    end else if (state == SEARCH && |local_PMA_position) begin
      PMA_local_offset <= low;
    end else if (state == LOCKED && !lose) begin
      PMA_local_data <= aligned;
      PMA_local_valid <= 1'b1;
      if (PMA_local_valid && !local_PMA_ready) PMA_local_overflow <= 1'b1;
    end else if (state == LOCKED || local_PMA_ready) begin
      PMA_local_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_parallel_match_aligner.sv
// tb_parallel_match_aligner: randomized scoreboard bench for parallel_match_aligner against a behavioural model.
module tb_parallel_match_aligner;
  localparam int W = 8, LAT = 2, NF = 16, NM = 3;
  logic clk = 0, rst = 1, ns = 0, rdy = 0;
  logic [W-1:0] bs = '0, pos = '0;
  logic busy, locked, valid, ovf;
  logic [2:0] off;
  logic [W-1:0] data;
  int checks = 0, failures = 0;
  logic [W-1:0] expq[$];
  typedef enum {M_IDLE, M_SEARCH, M_LOCKED} mst_t;
  mst_t m_st;
  int m_off, m_fr, m_miss;
  bit m_ovf, m_val;
  logic [W-1:0] m_dat;
  logic [W-1:0] hist[$];

  always #5 clk = ~clk;

  parallel_match_aligner #(.WID_Bitstream(W), .LAT_Position(LAT), .NUM_Frame(NF), .NUM_Miss(NM)) dut (
    .local_PMA_clk(clk), .local_PMA_reset(rst), .local_PMA_newstream(ns),
    .local_PMA_bitstream(bs), .local_PMA_position(pos),
    .PMA_local_busy(busy), .PMA_local_locked(locked), .PMA_local_offset(off),
    .PMA_local_data(data), .PMA_local_valid(valid), .local_PMA_ready(rdy),
    .PMA_local_overflow(ovf));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st = M_IDLE; m_off = 0; m_fr = 0; m_miss = 0; m_ovf = 0; m_val = 0; m_dat = '0;
    hist = {};
    repeat (LAT + 1) hist.push_front('0);
  endtask

  // hist[0] is the newest word; the mask seen now describes the word LAT cycles old
  task automatic model_edge(input logic n, input logic [W-1:0] w, input logic [W-1:0] m, input logic r);
    logic [W-1:0] dn, dn1, al;
    bit lose;
    int lo;
    dn = hist[LAT-1];
    dn1 = hist[LAT];
    al = W'({dn, dn1} >> m_off);
    lo = 0;
    for (int i = W - 1; i >= 0; i--) if (m[i]) lo = i;
    lose = 0;
    if (n) begin
      m_st = M_SEARCH; m_off = 0; m_fr = 0; m_miss = 0; m_ovf = 0; m_val = 0;
    end else if (m_st == M_SEARCH) begin
      if (m != 0) begin m_st = M_LOCKED; m_off = lo; m_fr = 0; m_miss = 0; end
    end else if (m_st == M_LOCKED) begin
`ifdef PMA_RECHECK_EN
      if (m_fr == NF - 1) begin
        if (m[m_off]) m_miss = 0;
        else m_miss++;
        lose = (m_miss == NM);
      end
      m_fr = (m_fr + 1) % NF;
`endif
      if (lose) begin
        m_st = M_SEARCH; m_val = 0;
      end else begin
        if (m_val && !r) m_ovf = 1;
        m_dat = al; m_val = 1;
      end
    end
    hist.push_front(w);
    void'(hist.pop_back());
  endtask

  task automatic step(input logic n, input logic [W-1:0] w, input logic [W-1:0] m, input logic r);
    ns = n; bs = w; pos = m; rdy = r;
    if (m_val && r) expq.push_back(m_dat);
    @(posedge clk);
    #1;
    model_edge(n, w, m, r);
    chk("busy", busy, m_st != M_IDLE);
    chk("locked", locked, m_st == M_LOCKED);
    chk("offset", off, m_off);
    chk("valid", valid, m_val);
    chk("overflow", ovf, m_ovf);
    chk("data", data, m_dat);
  endtask

  always @(negedge clk) begin : monitor
    logic [W-1:0] e;
    if (!rst && valid && rdy) begin
      checks++;
      if (expq.size() == 0) begin
        failures++;
        $display("FAIL scoreboard: unexpected word %0h, none expected", data);
      end else begin
        e = expq.pop_front();
        if (data !== e) begin
          failures++;
          $display("FAIL scoreboard: got %0h expected %0h at %0t", data, e, $time);
        end
      end
    end
  end

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_locked", locked, 0);
    chk("rst_valid", valid, 0);
    chk("rst_data", data, 0);
    rst = 0;
    // offset 3 on words A5, 3C
    step(1, 8'h00, 8'h00, 1);
    step(0, 8'hA5, 8'h00, 1);
    step(0, 8'h3C, 8'h00, 1);
    repeat (LAT - 2) step(0, 8'h00, 8'h00, 1);
    step(0, 8'h11, 8'h08, 1);
    chk("lock_a", locked, 1);
    chk("offset_a", off, 3);
    step(0, 8'h22, 8'h00, 1);
    chk("aligned_a", data, 8'h94);
    chk("valid_a", valid, 1);
    // lowest bit wins, offset frozen while locked, overflow sticky
    step(1, W'($urandom), 8'h00, 1);
    step(0, W'($urandom), 8'h24, 1);
    chk("offset_b", off, 2);
    step(0, W'($urandom), 8'h80, 1);
    step(0, W'($urandom), 8'h80, 1);
    chk("offset_hold", off, 2);
    step(0, W'($urandom), 8'h00, 0);
    step(0, W'($urandom), 8'h00, 0);
    chk("overflow_set", ovf, 1);
    step(1, W'($urandom), 8'h00, 1);
    chk("overflow_clr", ovf, 0);
    chk("valid_clr", valid, 0);
    // newstream beats a simultaneous mask
    step(0, W'($urandom), 8'h10, 1);
    step(0, W'($urandom), 8'h00, 1);
    step(1, W'($urandom), 8'hFF, 1);
    chk("ns_mask_locked", locked, 0);
    chk("ns_mask_busy", busy, 1);
    step(0, W'($urandom), 8'h01, 1);
    chk("offset_zero", off, 0);
    repeat (3) step(0, W'($urandom), 8'h00, 1);
`ifdef PMA_RECHECK_EN
    step(1, W'($urandom), 8'h00, 1);
    step(0, W'($urandom), 8'h02, 1);
    for (int i = 0; i < NF * 5; i++) begin
      step(0, W'($urandom), (i % NF == NF - 1 && i / NF == 1) ? 8'h02 : 8'h00, 1'($urandom_range(0, 1)));
      if (i == NF * 4 - 1) chk("recheck_hold", locked, 1);
    end
    chk("recheck_drop", locked, 0);
    chk("recheck_offset_kept", off, 1);
`endif
    for (int i = 0; i < 800; i++)
      step($urandom_range(0, 99) == 0, W'($urandom),
           $urandom_range(0, 7) == 0 ? W'($urandom) : 8'h00, $urandom_range(0, 3) != 0);
    // asynchronous reset while locked with valid high
    step(1, W'($urandom), 8'h00, 1);
    step(0, W'($urandom), 8'h40, 1);
    repeat (3) step(0, W'($urandom), 8'h00, 1);
    chk("pre_rst_valid", valid, 1);
    #2 rst = 1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_locked", locked, 0);
    chk("arst_offset", off, 0);
    chk("arst_data", data, 0);
    chk("arst_valid", valid, 0);
    chk("arst_overflow", ovf, 0);
    model_reset();
    expq.delete();
    @(posedge clk);
    #1 rst = 0;
    step(0, W'($urandom), 8'h01, 1);
    step(1, W'($urandom), 8'h00, 1);
    step(0, W'($urandom), 8'h04, 1);
    repeat (5) step(0, W'($urandom), 8'h00, 1);
    step(0, W'($urandom), 8'h00, 0);
    chk("queue_empty", expq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/parallel_match_aligner.md
# parallel_match_aligner

Word-aligning stage directly downstream of the parallel sequence detector. It consumes the per-bit match mask the detector produces together with the raw bitstream words. It locks onto the first reported match offset, then emits every subsequent stream word re-aligned so the sync pattern starts at bit 0. Output uses a valid/ready handshake toward the frame consumer. An optional frame-periodic recheck drops lock after repeated missing sync patterns.

## Interface
- WID_Bitstream, 8, bits per stream word; also the width of the match mask.
- LAT_Position, 2, detector latency in cycles from a raw word entering the detector to its mask appearing; the internal raw-word delay depth (≥1).
- NUM_Frame, 16, words per frame; the sync pattern recurs every NUM_Frame words (≥2).
- NUM_Miss, 3, consecutive missed sync checks that cause loss of lock (≥1).
- local_PMA_clk  in  1  clock; all logic on rising edge.
- local_PMA_reset  in  1  asynchronous, active-high reset.
- local_PMA_newstream  in  1  single-cycle pulse; restarts the search (driven with the detector's newstream).
- local_PMA_bitstream  in  WID_Bitstream  raw stream word, one per cycle, unqualified; bit 0 is the oldest bit.
- local_PMA_position  in  WID_Bitstream  detector match mask; bit i set means the pattern starts at bit i.
- PMA_local_busy  out  1  high when not IDLE.
- PMA_local_locked  out  1  high in LOCKED.
- PMA_local_offset  out  $clog2(WID_Bitstream)  latched alignment offset.
- PMA_local_data  out  WID_Bitstream  aligned word.
- PMA_local_valid  out  1  PMA_local_data valid.
- local_PMA_ready  in  1  consumer accepts when valid && ready.
- PMA_local_overflow  out  1  sticky; an aligned word was dropped.

## Operation
- Raw words pass through an LAT_Position-deep delay line. Stage outputs d[n] (newest) and d[n-1] line up with the current mask.
- States:
  - IDLE (reset state): ignores inputs.
  - SEARCH: waits for a nonzero mask.
  - LOCKED: produces aligned output.
- Transitions:
  - newstream in any state → SEARCH. Clears offset, frame and miss counters, overflow, and valid. Mask in the same cycle is ignored.
  - SEARCH with mask ≠ 0 → LOCKED. Offset is the index of the lowest set bit. Frame counter is 0.
  - LOCKED → SEARCH on loss of lock (recheck only).
  - Undefined state encoding → IDLE.
- Alignment: aligned word = low WID_Bitstream bits of ({d[n], d[n-1]} >> offset). Offset 0 yields d[n-1] unchanged.
- Frame counter (LOCKED): increments every cycle, wraps NUM_Frame−1 → 0.
- Output: each LOCKED cycle loads a new aligned word into the output register and sets valid.
  - If valid && !ready at that edge, the old word is overwritten and overflow sets.
  - Valid clears after acceptance when no new word is loaded.
- Leaving LOCKED clears valid on the same edge.

## Timing
- Reset: busy, locked, offset, data, valid, overflow all 0; state IDLE; delay line and counters 0.
- Mask nonzero at edge t (SEARCH) → locked and offset visible after t. The first aligned word has valid high from the cycle after edge t+1.
- Steady-state throughput is one word per cycle; latency from mask to aligned word is 1 cycle.
- Overflow stays set until reset or newstream.
- Mid-operation reset: all state returns to its reset value immediately (asynchronous).
- Offset does not change while LOCKED, even if a different mask bit is set.

## Configuration
- PMA_RECHECK_EN defined:
  - When the frame counter = NUM_Frame−1, mask bit [offset] is checked.
  - Set: miss counter clears. Clear: miss counter increments.
  - Reaching NUM_Miss → SEARCH, locked low, valid cleared, offset kept until the next lock.
- Undefined: no frame or miss counters; lock is held until newstream or reset.

## Test plan
- Reset asserted mid-LOCKED with valid=1 → all outputs 0 in the same cycle; state IDLE.
- newstream, then mask 8'b0000_1000 with words 0xA5, 0x3C → offset=3, locked=1. The next aligned word equals ({0x3C,0xA5} >> 3) & 0xFF = 0x94.
- Mask 8'b0010_0100 in SEARCH → offset=2 (lowest bit). A later mask 8'b1000_0000 while LOCKED → offset stays 2.
- ready held 0 for 2 LOCKED cycles → overflow=1, data holds the latest word. newstream → overflow=0, valid=0.
- PMA_RECHECK_EN, NUM_Frame=16, NUM_Miss=3, sync missing at 3 consecutive boundaries → locked drops 1 cycle after the 3rd boundary. Sync present at the 2nd boundary → miss counter resets and lock is held.
- newstream coinciding with a nonzero mask → state SEARCH, locked=0. The next-cycle mask 8'b0000_0001 → offset=0, output = d[n-1].
